// File: rtl/multicycle_control_fsm.sv
// ============================================================================
// Module   : multicycle_control_fsm
// Brief    : Main control FSM for a multicycle MIPS datapath with MemReady stalls.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_control_fsm #(
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [5:0]      i_opcode,
  input  logic [5:0]      i_funct,
  input  logic            i_zero,
  input  logic            i_mem_ready,
  output logic            o_pc_en,
  output logic            o_iord,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic            o_ir_write,
  output logic            o_reg_dst,
  output logic            o_mem_to_reg,
  output logic            o_reg_write,
  output logic            o_alu_src_a,
  output logic [1:0]      o_alu_src_b,
  output logic [2:0]      o_alu_op,
  output logic [1:0]      o_pc_source,
  output logic            o_ext_op,
  output logic            o_illegal,
  output logic            o_instr_done,
  output logic [ST_W-1:0] o_state
);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ANDI  = 6'b001100;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;

  typedef enum logic [ST_W-1:0] {
    S_FETCH    = ST_W'(0),
    S_DECODE   = ST_W'(1),
    S_MEM_ADDR = ST_W'(2),
    S_MEM_RD   = ST_W'(3),
    S_MEM_WB   = ST_W'(4),
    S_MEM_WR   = ST_W'(5),
    S_R_EXEC   = ST_W'(6),
    S_R_WB     = ST_W'(7),
    S_BRANCH   = ST_W'(8),
    S_JUMP     = ST_W'(9),
    S_I_EXEC   = ST_W'(10),
    S_I_WB     = ST_W'(11)
  } state_t;

  state_t r_state;
  logic   w_pc_write;
  logic   w_pc_write_cond;
  logic   w_branch_ne;
  logic   w_ext_sign;
  logic   w_unused_funct;

  // Funct is decoded by the ALU control block, not here.
  assign w_unused_funct = ^i_funct;
  assign w_ext_sign     = !((i_opcode == c_OP_ANDI) || (i_opcode == c_OP_ORI));
  assign o_state        = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:    r_state <= i_mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (i_opcode)
            c_OP_RTYPE:                     r_state <= S_R_EXEC;
            c_OP_LW, c_OP_SW:               r_state <= S_MEM_ADDR;
            c_OP_BEQ, c_OP_BNE:             r_state <= S_BRANCH;
            c_OP_J:                         r_state <= S_JUMP;
            c_OP_ADDI, c_OP_ANDI, c_OP_ORI: r_state <= S_I_EXEC;
            default:                        r_state <= S_FETCH;
          endcase
        end
        S_MEM_ADDR: r_state <= (i_opcode == c_OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   r_state <= i_mem_ready ? S_MEM_WB : S_MEM_RD;
        S_MEM_WR:   r_state <= i_mem_ready ? S_FETCH : S_MEM_WR;
        S_R_EXEC:   r_state <= S_R_WB;
        S_I_EXEC:   r_state <= S_I_WB;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_branch_ne     = 1'b0;
    o_iord          = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_ir_write      = 1'b0;
    o_reg_dst       = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_reg_write     = 1'b0;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = 2'b00;
    o_alu_op        = 3'b000;
    o_pc_source     = 2'b00;
    o_ext_op        = 1'b0;
    o_illegal       = 1'b0;
    o_instr_done    = 1'b0;
    o_pc_en         = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = 2'b01;
        o_ir_write  = i_mem_ready;
        w_pc_write  = i_mem_ready;
        o_ext_op    = 1'b1;
      end
      S_DECODE: begin
        o_alu_src_b = 2'b11;
        o_ext_op    = 1'b1;
        case (i_opcode)
          c_OP_RTYPE, c_OP_LW, c_OP_SW, c_OP_BEQ, c_OP_BNE,
          c_OP_J, c_OP_ADDI, c_OP_ANDI, c_OP_ORI: o_illegal = 1'b0;
          default:                                o_illegal = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        o_ext_op    = w_ext_sign;
      end
      S_MEM_RD: begin
        o_iord      = 1'b1;
        o_mem_read  = 1'b1;
        o_ext_op    = w_ext_sign;
      end
      S_MEM_WB: begin
        o_mem_to_reg = 1'b1;
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
        o_ext_op     = w_ext_sign;
      end
      S_MEM_WR: begin
        o_iord       = 1'b1;
        o_mem_write  = 1'b1;
        o_instr_done = i_mem_ready;
        o_ext_op     = w_ext_sign;
      end
      S_R_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = 3'b010;
        o_ext_op    = w_ext_sign;
      end
      S_R_WB: begin
        o_reg_dst    = 1'b1;
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
        o_ext_op     = w_ext_sign;
      end
      S_BRANCH: begin
        o_alu_src_a     = 1'b1;
        o_alu_op        = 3'b001;
        o_pc_source     = 2'b01;
        w_pc_write_cond = 1'b1;
        w_branch_ne     = (i_opcode == c_OP_BNE);
        o_instr_done    = 1'b1;
        o_ext_op        = w_ext_sign;
      end
      S_JUMP: begin
        o_pc_source  = 2'b10;
        w_pc_write   = 1'b1;
        o_instr_done = 1'b1;
        o_ext_op     = w_ext_sign;
      end
      S_I_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        o_ext_op    = w_ext_sign;
        case (i_opcode)
          c_OP_ANDI: o_alu_op = 3'b011;
          c_OP_ORI:  o_alu_op = 3'b100;
          default:   o_alu_op = 3'b000;
        endcase
      end
      S_I_WB: begin
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
        o_ext_op     = w_ext_sign;
      end
      default: ;
    endcase
    o_pc_en = w_pc_write | (w_pc_write_cond & (i_zero ^ w_branch_ne));
    // Reset dominates combinationally so no write can complete mid-instruction.
    if (!rst_n) begin
      o_pc_en      = 1'b0;
      o_iord       = 1'b0;
      o_mem_read   = 1'b0;
      o_mem_write  = 1'b0;
      o_ir_write   = 1'b0;
      o_reg_dst    = 1'b0;
      o_mem_to_reg = 1'b0;
      o_reg_write  = 1'b0;
      o_alu_src_a  = 1'b0;
      o_alu_src_b  = 2'b00;
      o_alu_op     = 3'b000;
      o_pc_source  = 2'b00;
      o_ext_op     = 1'b0;
      o_illegal    = 1'b0;
      o_instr_done = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
// ============================================================================
// Module   : tb_multicycle_control_fsm
// Brief    : Directed scoreboard bench for the multicycle control FSM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control_fsm;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // Vector layout: pcen iord mr mw irw rd m2r rw sa | srcb | aluop | pcsrc | ext ill done
  localparam logic [18:0] V_ZERO   = 19'd0;
  localparam logic [18:0] V_F_WAIT = {9'b001000000, 2'b01, 3'b000, 2'b00, 3'b100};
  localparam logic [18:0] V_F_RDY  = {9'b101010000, 2'b01, 3'b000, 2'b00, 3'b100};
  localparam logic [18:0] V_DEC    = {9'b000000000, 2'b11, 3'b000, 2'b00, 3'b100};
  localparam logic [18:0] V_DEC_IL = {9'b000000000, 2'b11, 3'b000, 2'b00, 3'b110};
  localparam logic [18:0] V_MADDR  = {9'b000000001, 2'b10, 3'b000, 2'b00, 3'b100};
  localparam logic [18:0] V_MRD    = {9'b011000000, 2'b00, 3'b000, 2'b00, 3'b100};
  localparam logic [18:0] V_MWB    = {9'b000000110, 2'b00, 3'b000, 2'b00, 3'b101};
  localparam logic [18:0] V_MWR_W  = {9'b010100000, 2'b00, 3'b000, 2'b00, 3'b100};
  localparam logic [18:0] V_MWR_R  = {9'b010100000, 2'b00, 3'b000, 2'b00, 3'b101};
  localparam logic [18:0] V_REX    = {9'b000000001, 2'b00, 3'b010, 2'b00, 3'b100};
  localparam logic [18:0] V_RWB    = {9'b000001010, 2'b00, 3'b000, 2'b00, 3'b101};
  localparam logic [18:0] V_JMP    = {9'b100000000, 2'b00, 3'b000, 2'b10, 3'b101};

  function automatic logic [18:0] v_br(input logic pcen);
    return {pcen, 8'b00000001, 2'b00, 3'b001, 2'b01, 3'b101};
  endfunction
  function automatic logic [18:0] v_iex(input logic [2:0] op, input logic ext);
    return {9'b000000001, 2'b10, op, 2'b00, ext, 2'b00};
  endfunction
  function automatic logic [18:0] v_iwb(input logic ext);
    return {9'b000000010, 2'b00, 3'b000, 2'b00, ext, 2'b01};
  endfunction

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] i_opcode;
  logic [5:0] i_funct;
  logic       i_zero;
  logic       i_mem_ready;
  logic       o_pc_en, o_iord, o_mem_read, o_mem_write, o_ir_write;
  logic       o_reg_dst, o_mem_to_reg, o_reg_write, o_alu_src_a;
  logic [1:0] o_alu_src_b, o_pc_source;
  logic [2:0] o_alu_op;
  logic       o_ext_op, o_illegal, o_instr_done;
  logic [3:0] o_state;
  logic [18:0] w_ov;

  int total = 0;
  int bad   = 0;
  int rw_cnt = 0;

  string       tag_q[$];
  logic [3:0]  st_q[$];
  logic [18:0] v_q[$];

  always #5 clk = ~clk;

  assign w_ov = {o_pc_en, o_iord, o_mem_read, o_mem_write, o_ir_write, o_reg_dst,
                 o_mem_to_reg, o_reg_write, o_alu_src_a, o_alu_src_b, o_alu_op,
                 o_pc_source, o_ext_op, o_illegal, o_instr_done};

  multicycle_control_fsm #(.ST_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_opcode     (i_opcode),
    .i_funct      (i_funct),
    .i_zero       (i_zero),
    .i_mem_ready  (i_mem_ready),
    .o_pc_en      (o_pc_en),
    .o_iord       (o_iord),
    .o_mem_read   (o_mem_read),
    .o_mem_write  (o_mem_write),
    .o_ir_write   (o_ir_write),
    .o_reg_dst    (o_reg_dst),
    .o_mem_to_reg (o_mem_to_reg),
    .o_reg_write  (o_reg_write),
    .o_alu_src_a  (o_alu_src_a),
    .o_alu_src_b  (o_alu_src_b),
    .o_alu_op     (o_alu_op),
    .o_pc_source  (o_pc_source),
    .o_ext_op     (o_ext_op),
    .o_illegal    (o_illegal),
    .o_instr_done (o_instr_done),
    .o_state      (o_state)
  );

  task automatic push_exp(input string tag, input logic [3:0] st, input logic [18:0] v);
    tag_q.push_back(tag);
    st_q.push_back(st);
    v_q.push_back(v);
  endtask

  task automatic pop_check();
    string       t;
    logic [3:0]  es;
    logic [18:0] ev;
    t  = tag_q.pop_front();
    es = st_q.pop_front();
    ev = v_q.pop_front();
    if (o_reg_write === 1'b1) rw_cnt++;
    total++;
    assert (o_state === es) else begin
      bad++;
      $error("FAIL %s state observed=%0d expected=%0d", t, o_state, es);
    end
    total++;
    assert (w_ov === ev) else begin
      bad++;
      $error("FAIL %s outputs observed=%b expected=%b", t, w_ov, ev);
    end
  endtask

  // Drive one cycle's inputs, sample mid-cycle, then advance past the edge.
  task automatic cyc(input string tag, input logic [5:0] opc, input logic z,
                     input logic mr, input logic [3:0] st, input logic [18:0] v);
    i_opcode    = opc;
    i_zero      = z;
    i_mem_ready = mr;
    push_exp(tag, st, v);
    @(negedge clk);
    pop_check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    i_opcode    = OP_LW;
    i_funct     = 6'b100000;
    i_zero      = 1'b0;
    i_mem_ready = 1'b1;
    #2;
    push_exp("reset", 4'd0, V_ZERO);
    pop_check();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // lw with two wait cycles in FETCH and in MEM_RD: 9 cycles total
    rw_cnt = 0;
    cyc("lw_f0",  OP_LW, 1'b0, 1'b0, 4'd0, V_F_WAIT);
    cyc("lw_f1",  OP_LW, 1'b0, 1'b0, 4'd0, V_F_WAIT);
    cyc("lw_f2",  OP_LW, 1'b0, 1'b1, 4'd0, V_F_RDY);
    cyc("lw_dec", OP_LW, 1'b0, 1'b1, 4'd1, V_DEC);
    cyc("lw_ma",  OP_LW, 1'b0, 1'b1, 4'd2, V_MADDR);
    cyc("lw_rd0", OP_LW, 1'b0, 1'b0, 4'd3, V_MRD);
    cyc("lw_rd1", OP_LW, 1'b0, 1'b0, 4'd3, V_MRD);
    cyc("lw_rd2", OP_LW, 1'b0, 1'b1, 4'd3, V_MRD);
    cyc("lw_wb",  OP_LW, 1'b0, 1'b1, 4'd4, V_MWB);
    total++;
    assert (rw_cnt === 1) else begin
      bad++;
      $error("FAIL lw_regwrite_count observed=%0d expected=1", rw_cnt);
    end

    // branches: PCEn = Zero ^ BranchNe
    cyc("beq1_f", OP_BEQ, 1'b1, 1'b1, 4'd0, V_F_RDY);
    cyc("beq1_d", OP_BEQ, 1'b1, 1'b1, 4'd1, V_DEC);
    cyc("beq1_b", OP_BEQ, 1'b1, 1'b1, 4'd8, v_br(1'b1));
    cyc("beq0_f", OP_BEQ, 1'b0, 1'b1, 4'd0, V_F_RDY);
    cyc("beq0_d", OP_BEQ, 1'b0, 1'b1, 4'd1, V_DEC);
    cyc("beq0_b", OP_BEQ, 1'b0, 1'b1, 4'd8, v_br(1'b0));
    cyc("bne1_f", OP_BNE, 1'b1, 1'b1, 4'd0, V_F_RDY);
    cyc("bne1_d", OP_BNE, 1'b1, 1'b1, 4'd1, V_DEC);
    cyc("bne1_b", OP_BNE, 1'b1, 1'b1, 4'd8, v_br(1'b0));
    cyc("bne0_f", OP_BNE, 1'b0, 1'b1, 4'd0, V_F_RDY);
    cyc("bne0_d", OP_BNE, 1'b0, 1'b1, 4'd1, V_DEC);
    cyc("bne0_b", OP_BNE, 1'b0, 1'b1, 4'd8, v_br(1'b1));

    // immediates: zero-extend for andi/ori only after DECODE
    cyc("andi_f", OP_ANDI, 1'b0, 1'b1, 4'd0,  V_F_RDY);
    cyc("andi_d", OP_ANDI, 1'b0, 1'b1, 4'd1,  V_DEC);
    cyc("andi_x", OP_ANDI, 1'b0, 1'b1, 4'd10, v_iex(3'b011, 1'b0));
    cyc("andi_w", OP_ANDI, 1'b0, 1'b1, 4'd11, v_iwb(1'b0));
    cyc("addi_f", OP_ADDI, 1'b0, 1'b1, 4'd0,  V_F_RDY);
    cyc("addi_d", OP_ADDI, 1'b0, 1'b1, 4'd1,  V_DEC);
    cyc("addi_x", OP_ADDI, 1'b0, 1'b1, 4'd10, v_iex(3'b000, 1'b1));
    cyc("addi_w", OP_ADDI, 1'b0, 1'b1, 4'd11, v_iwb(1'b1));
    cyc("ori_f",  OP_ORI,  1'b0, 1'b1, 4'd0,  V_F_RDY);
    cyc("ori_d",  OP_ORI,  1'b0, 1'b1, 4'd1,  V_DEC);
    cyc("ori_x",  OP_ORI,  1'b0, 1'b1, 4'd10, v_iex(3'b100, 1'b0));
    cyc("ori_w",  OP_ORI,  1'b0, 1'b1, 4'd11, v_iwb(1'b0));

    cyc("r_f",  OP_R, 1'b0, 1'b1, 4'd0, V_F_RDY);
    cyc("r_d",  OP_R, 1'b0, 1'b1, 4'd1, V_DEC);
    cyc("r_x",  OP_R, 1'b0, 1'b1, 4'd6, V_REX);
    cyc("r_w",  OP_R, 1'b0, 1'b1, 4'd7, V_RWB);

    cyc("ill_f",  OP_BAD, 1'b0, 1'b1, 4'd0, V_F_RDY);
    cyc("ill_d",  OP_BAD, 1'b0, 1'b1, 4'd1, V_DEC_IL);
    cyc("ill_f2", OP_BAD, 1'b0, 1'b0, 4'd0, V_F_WAIT);

    cyc("j_f", OP_J, 1'b0, 1'b1, 4'd0, V_F_RDY);
    cyc("j_d", OP_J, 1'b0, 1'b1, 4'd1, V_DEC);
    cyc("j_j", OP_J, 1'b0, 1'b0, 4'd9, V_JMP);

    cyc("sw_f",  OP_SW, 1'b0, 1'b1, 4'd0, V_F_RDY);
    cyc("sw_d",  OP_SW, 1'b0, 1'b1, 4'd1, V_DEC);
    cyc("sw_ma", OP_SW, 1'b0, 1'b1, 4'd2, V_MADDR);
    cyc("sw_w0", OP_SW, 1'b0, 1'b0, 4'd5, V_MWR_W);
    cyc("sw_w1", OP_SW, 1'b0, 1'b1, 4'd5, V_MWR_R);
    cyc("sw_f2", OP_SW, 1'b0, 1'b1, 4'd0, V_F_RDY);
    cyc("sw2_d", OP_SW, 1'b0, 1'b1, 4'd1, V_DEC);
    cyc("sw2_ma", OP_SW, 1'b0, 1'b1, 4'd2, V_MADDR);
    cyc("sw2_w0", OP_SW, 1'b0, 1'b0, 4'd5, V_MWR_W);

    // asynchronous reset while stalled in MEM_WR
    rst_n = 1'b0;
    #1;
    push_exp("rst_mwr", 4'd0, V_ZERO);
    pop_check();
    i_mem_ready = 1'b1;
    @(posedge clk); #1;
    push_exp("rst_hold", 4'd0, V_ZERO);
    pop_check();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("post_rst_f", OP_SW, 1'b0, 1'b0, 4'd0, V_F_WAIT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
